// File: rtl/csa_pkg.sv
// Shared types, default sizes and helpers for the carry-save accumulator.
package csa_pkg;

  // Control states: folding beats, resolving the redundant pair, offering result
  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int DEF_W     = 4;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_CHUNK = 2;
  localparam int DEF_CNT_W = 8;

  // Increment v, holding at the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: per bit, sum = a^b^c and carry = majority(a,b,c).
// The carry vector is returned unshifted; the caller aligns it.
module csa_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  // Bitwise full-adder cells with no carry chain between them
  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/csa_accumulator.sv
// Sequential multi-operand accumulator. Beats are folded into a redundant
// sum/carry pair with one 3:2 compression each, then the pair is resolved to
// binary a CHUNK-bit slice per cycle before being offered downstream.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CHUNK = DEF_CHUNK,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int N   = ACC_W / CHUNK;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets the chunked resolver and zero-extension cannot handle
  generate
    if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
      $error("csa_accumulator: ACC_W must be a multiple of CHUNK");
    end
    if (W > ACC_W) begin : g_bad_width
      $error("csa_accumulator: W must not exceed ACC_W");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             cc_q, cc_d;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] row_sum;
  logic [ACC_W-1:0] row_maj;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK-1:0] c_chunk;
  logic [CHUNK:0]   chunk_add;
  logic             beat_take;
  logic             last_chunk;

  assign x = ACC_W'(in_data);

  csa_row #(
    .WIDTH(ACC_W)
  ) u_row (
    .a    (s_q),
    .b    (c_q),
    .c    (x),
    .sum  (row_sum),
    .carry(row_maj)
  );

  // Slice k of S+C plus the carry rippled in from the previous slice
  always_comb begin
    s_chunk    = s_q[k_q*CHUNK +: CHUNK];
    c_chunk    = c_q[k_q*CHUNK +: CHUNK];
    chunk_add  = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK+1)'(cc_q);
    last_chunk = (k_q == K_W'(N - 1));
    beat_take  = in_valid && (state_q == ACC);
  end

  // Next-state and datapath update for fold, resolve and hand-off
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    cc_d    = cc_q;
    case (state_q)
      ACC: begin
        if (beat_take) begin
          s_d   = row_sum;
          c_d   = row_maj << 1;
          // The majority bit shifted out of C is one whole 2^ACC_W lost
          ovf_d = ovf_q | row_maj[ACC_W-1];
          cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
          if (in_last) begin
            state_d = RESOLVE;
            k_d     = '0;
            cc_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        s_d[k_q*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
        cc_d = chunk_add[CHUNK];
        k_d  = k_q + 1'b1;
        if (last_chunk) begin
          ovf_d   = ovf_q | chunk_add[CHUNK];
          c_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and datapath registers; reset discards any packet in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
      cc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
      cc_q    <= cc_d;
    end
  end

  // Handshake flags decode the state; result fields come straight from flops
  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    out_sum   = s_q;
    out_count = cnt_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: directed packets with literal expectations plus
// randomized packets, all cross-checked each cycle against a packet-level model.
module tb_csa_accumulator;

  localparam int ACC_W   = 8;
  localparam int MODULUS = 256;
  localparam int CNT_MAX = 255;
  localparam int LAT     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic [7:0] out_count;
  logic       out_ovf;

  int checks = 0;
  int failures = 0;

  csa_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: running integer total, beat count, and a phase
  // timeline (accepting / waiting LAT edges / result offered).
  int m_phase = 0;
  int m_wait  = 0;
  int m_total = 0;
  int m_n     = 0;
  int r_sum   = 0;
  int r_cnt   = 0;
  int r_ovf   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_wait  = 0;
      m_total = 0;
      m_n     = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_total += int'(in_data);
          m_n++;
          if (in_last) begin
            r_sum   = m_total % MODULUS;
            r_cnt   = (m_n > CNT_MAX) ? CNT_MAX : m_n;
            r_ovf   = (m_total >= MODULUS) ? 1 : 0;
            m_phase = 1;
            m_wait  = LAT;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_phase = 2;
        end
        default: if (out_ready) begin
          m_phase = 0;
          m_total = 0;
          m_n     = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_in_ready", int'(in_ready), (m_phase == 0) ? 1 : 0);
      chk("cyc_out_valid", int'(out_valid), (m_phase == 2) ? 1 : 0);
      if (m_phase == 2) begin
        chk("cyc_out_sum", int'(out_sum), r_sum);
        chk("cyc_out_count", int'(out_count), r_cnt);
        chk("cyc_out_ovf", int'(out_ovf), r_ovf);
      end
    end
  end

  task automatic send(input int d, input bit last, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d[3:0];
    in_last  = last;
  endtask

  // Wait (bounded) for the result, pin it to literals, hold, then hand off
  task automatic finish_packet(input string nm, input int es, input int ec,
                               input int eo, input int hold);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (out_valid) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_latency"}, lat, LAT);
      chk({nm, "_sum"}, int'(out_sum), es);
      chk({nm, "_count"}, int'(out_count), ec);
      chk({nm, "_ovf"}, int'(out_ovf), eo);
      $display("packet %s sum=%0d count=%0d ovf=%0d latency=%0d", nm,
               out_sum, out_count, out_ovf, lat);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 4'($urandom_range(0, 15));
        in_last  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_ready_back"}, int'(in_ready), 1);
    end
  endtask

  initial begin
    int tot;
    int len;
    int d;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Back-to-back 3,5,7
    send(3, 0, 0); send(5, 0, 0); send(7, 1, 0);
    finish_packet("p357", 15, 3, 0, 0);

    // Carry into and past bit ACC_W
    for (int i = 0; i < 17; i++) send(15, i == 16, 0);
    finish_packet("f17", 255, 17, 0, 0);
    for (int i = 0; i < 17; i++) send(15, 0, 0);
    send(1, 1, 0);
    finish_packet("f17p1", 0, 18, 1, 0);
    for (int i = 0; i < 20; i++) send(15, i == 19, 0);
    finish_packet("f20", 44, 20, 1, 0);

    // Single-beat packet, then gapped packet held in DONE with in_valid noise
    send(9, 1, 0);
    finish_packet("single9", 9, 1, 0, 0);
    send(2, 0, 2); send(0, 0, 1); send(6, 1, 3);
    finish_packet("gap206", 8, 3, 0, 5);
    send(1, 0, 0); send(2, 1, 0);
    finish_packet("p12", 3, 2, 0, 0);

    // Asynchronous reset while resolving
    send(5, 0, 0); send(6, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_sum", int'(out_sum), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(4, 0, 0); send(4, 1, 0);
    finish_packet("p44", 8, 2, 0, 0);

    // Beat counter saturation
    for (int i = 0; i < 260; i++) send(0, i == 259, 0);
    finish_packet("sat260", 0, CNT_MAX, 0, 0);

    // Randomized packets
    for (int p = 0; p < 25; p++) begin
      len = int'($urandom_range(1, 40));
      tot = 0;
      for (int b = 0; b < len; b++) begin
        d = int'($urandom_range(0, 15));
        tot += d;
        send(d, b == len - 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      finish_packet("rand", tot % MODULUS, (len > CNT_MAX) ? CNT_MAX : len,
                    (tot >= MODULUS) ? 1 : 0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
